// File: rtl/simplest_para_n.sv
// rtl/simplest_para_n.sv - NUM_CORES parallel single-cycle accumulator cores with private program memories
// Shared program write port, common launch, per-core halt flags and a saturating run-cycle counter.
module simplest_para_n #(
  parameter int NUM_CORES  = 4,
  parameter int ACC_W      = 8,
  parameter int PROG_DEPTH = 16,
  localparam int AW = $clog2(PROG_DEPTH),
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    preset,
  input  logic                    prog_we,
  input  logic [CW-1:0]           prog_core,
  input  logic [AW-1:0]           prog_addr,
  input  logic [ACC_W+3:0]        prog_data,
  output logic                    prog_err,
  input  logic                    start,
  output logic [NUM_CORES*ACC_W-1:0] acc_out,
  output logic [NUM_CORES*AW-1:0] pc_out,
  output logic [NUM_CORES-1:0]    halted,
  output logic                    busy,
  output logic                    all_done,
  output logic [15:0]             run_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  logic [ACC_W+3:0] mem [NUM_CORES][PROG_DEPTH];

  state_t           state_q [NUM_CORES];
  state_t           state_d [NUM_CORES];
  logic [ACC_W-1:0] acc_q   [NUM_CORES];
  logic [ACC_W-1:0] acc_d   [NUM_CORES];
  logic [AW-1:0]    pc_q    [NUM_CORES];
  logic [AW-1:0]    pc_d    [NUM_CORES];
  logic [ACC_W+3:0] instr   [NUM_CORES];
  logic [NUM_CORES-1:0] running;
  logic [NUM_CORES-1:0] done_d;

  logic core_ok, wr_ok, launch;

  assign core_ok = (32'(prog_core) < NUM_CORES);
  assign wr_ok   = prog_we && !busy && core_ok;
  assign launch  = start && !busy;

  always_comb begin
    running = '0;
    for (int k = 0; k < NUM_CORES; k++) running[k] = (state_q[k] == RUN);
  end
  assign busy = |running;

  // Per-core next state; launch overrides everything so a relaunch always starts clean.
  always_comb begin
    done_d = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      state_d[k] = state_q[k];
      acc_d[k]   = acc_q[k];
      pc_d[k]    = pc_q[k];
      instr[k]   = mem[k][pc_q[k]];
      if (launch) begin
        state_d[k] = RUN;
        acc_d[k]   = '0;
        pc_d[k]    = '0;
      end else if (state_q[k] == RUN) begin
        pc_d[k] = pc_q[k] + AW'(1);
        case (instr[k][ACC_W+3:ACC_W])
          4'd0: begin
            state_d[k] = HALTED;
            pc_d[k]    = pc_q[k];
          end
          4'd2:  acc_d[k] = instr[k][ACC_W-1:0];
          4'd3:  acc_d[k] = acc_q[k] + instr[k][ACC_W-1:0];
          4'd4:  acc_d[k] = acc_q[k] - instr[k][ACC_W-1:0];
          4'd5:  acc_d[k] = acc_q[k] & instr[k][ACC_W-1:0];
          4'd6:  acc_d[k] = acc_q[k] | instr[k][ACC_W-1:0];
          4'd7:  acc_d[k] = acc_q[k] ^ instr[k][ACC_W-1:0];
          4'd8:  pc_d[k] = instr[k][AW-1:0];
          4'd9:  if (acc_q[k] != '0) pc_d[k] = instr[k][AW-1:0];
          4'd10: if (acc_q[k] == '0) pc_d[k] = instr[k][AW-1:0];
          default: ;
        endcase
      end
      done_d[k] = (state_d[k] == HALTED);
    end
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      for (int c = 0; c < NUM_CORES; c++)
        for (int a = 0; a < PROG_DEPTH; a++) mem[c][a] <= '0;
    end else if (wr_ok) begin
      mem[prog_core][prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        state_q[k] <= IDLE;
        acc_q[k]   <= '0;
        pc_q[k]    <= '0;
      end
      all_done   <= 1'b0;
      run_cycles <= '0;
      prog_err   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        state_q[k] <= state_d[k];
        acc_q[k]   <= acc_d[k];
        pc_q[k]    <= pc_d[k];
      end
      all_done <= &done_d;
      prog_err <= prog_we && (busy || !core_ok);
      if (launch)
        run_cycles <= '0;
      else if (busy && run_cycles != 16'hFFFF)
        run_cycles <= run_cycles + 16'd1;
    end
  end

  always_comb begin
    acc_out = '0;
    pc_out  = '0;
    halted  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      acc_out[k*ACC_W +: ACC_W] = acc_q[k];
      pc_out[k*AW +: AW]        = pc_q[k];
      halted[k]                 = (state_q[k] == HALTED);
    end
  end

endmodule

// File: tb/tb_simplest_para_n.sv
// tb/tb_simplest_para_n.sv - directed self-checking bench for simplest_para_n
// Three instances: default 4x8-bit, single core, and 8 cores of 16 bits.
module tb_simplest_para_n;

  logic clk = 1'b0;
  logic preset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        we0 = 0, start0 = 0, err0, busy0, done0;
  logic [1:0]  core0 = '0;
  logic [3:0]  addr0 = '0;
  logic [11:0] data0 = '0;
  logic [31:0] acc0;
  logic [15:0] pc0, rc0;
  logic [3:0]  halted0;

  logic        we1 = 0, start1 = 0, err1, busy1, done1;
  logic [0:0]  core1 = '0;
  logic [3:0]  addr1 = '0;
  logic [11:0] data1 = '0;
  logic [7:0]  acc1;
  logic [3:0]  pc1;
  logic [15:0] rc1;
  logic [0:0]  halted1;

  logic         we2 = 0, start2 = 0, err2, busy2, done2;
  logic [2:0]   core2 = '0;
  logic [3:0]   addr2 = '0;
  logic [19:0]  data2 = '0;
  logic [127:0] acc2;
  logic [31:0]  pc2;
  logic [15:0]  rc2;
  logic [7:0]   halted2;

  simplest_para_n u0 (
    .clk(clk), .preset(preset), .prog_we(we0), .prog_core(core0), .prog_addr(addr0),
    .prog_data(data0), .prog_err(err0), .start(start0), .acc_out(acc0), .pc_out(pc0),
    .halted(halted0), .busy(busy0), .all_done(done0), .run_cycles(rc0));

  simplest_para_n #(.NUM_CORES(1)) u1 (
    .clk(clk), .preset(preset), .prog_we(we1), .prog_core(core1), .prog_addr(addr1),
    .prog_data(data1), .prog_err(err1), .start(start1), .acc_out(acc1), .pc_out(pc1),
    .halted(halted1), .busy(busy1), .all_done(done1), .run_cycles(rc1));

  simplest_para_n #(.NUM_CORES(8), .ACC_W(16)) u2 (
    .clk(clk), .preset(preset), .prog_we(we2), .prog_core(core2), .prog_addr(addr2),
    .prog_data(data2), .prog_err(err2), .start(start2), .acc_out(acc2), .pc_out(pc2),
    .halted(halted2), .busy(busy2), .all_done(done2), .run_cycles(rc2));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int c, input int a, input int op, input int imm);
    core0 = 2'(c); addr0 = 4'(a); data0 = {4'(op), 8'(imm)}; we0 = 1;
    tick();
    we0 = 0;
  endtask

  task automatic go0();
    start0 = 1;
    tick();
    start0 = 0;
  endtask

  task automatic wr2(input int c, input int a, input int op, input int imm);
    core2 = 3'(c); addr2 = 4'(a); data2 = {4'(op), 16'(imm)}; we2 = 1;
    tick();
    we2 = 0;
  endtask

  initial begin
    #1 preset = 0;
    #2 preset = 1;
    #1;
    chk("rst_acc", acc0, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);

    // empty memories: every core halts after one RUN cycle
    go0();
    chk("empty_busy", busy0, 1);
    tick();
    chk("empty_halted", halted0, 4'hF);
    chk("empty_rc", rc0, 1);
    chk("empty_done", done0, 1);

    // straight line on core0
    wr0(0, 0, 2, 5);
    chk("wr_ok_err", err0, 0);
    wr0(0, 1, 3, 3);
    wr0(0, 2, 0, 0);
    go0();
    chk("sl_relaunch_done", done0, 0);
    tick();
    chk("sl_e1_halted", halted0, 4'b1110);
    tick();
    chk("sl_e2_done", done0, 0);
    tick();
    chk("sl_acc", acc0[7:0], 8);
    chk("sl_pc", pc0[3:0], 2);
    chk("sl_halted", halted0, 4'hF);
    chk("sl_done", done0, 1);
    chk("sl_rc", rc0, 3);

    // countdown loop, core k loads k+3
    for (int k = 0; k < 4; k++) begin
      wr0(k, 0, 2, k + 3);
      wr0(k, 1, 4, 1);
      wr0(k, 2, 9, 1);
      wr0(k, 3, 0, 0);
    end
    go0();
    core0 = 0; addr0 = 0; data0 = {4'd2, 8'd99}; we0 = 1;
    tick();
    we0 = 0;
    chk("busy_wr_err", err0, 1);
    tick();
    chk("busy_wr_err_pulse", err0, 0);
    tick(5);
    chk("lp_e7_h0", halted0[0], 0);
    tick();
    chk("lp_e8_halted", halted0, 4'b0001);
    chk("lp_e8_acc0", acc0[7:0], 0);
    chk("lp_e8_pc0", pc0[3:0], 3);
    tick(2);
    chk("lp_e10_halted", halted0, 4'b0011);
    tick(3);
    chk("lp_e13_halted", halted0, 4'b0111);
    chk("lp_e13_done", done0, 0);
    tick();
    chk("lp_e14_halted", halted0, 4'hF);
    chk("lp_e14_done", done0, 1);
    chk("lp_e14_acc", acc0, 0);
    chk("lp_e14_rc", rc0, 14);
    chk("lp_e14_busy", busy0, 0);

    // relaunch after all_done; start while busy ignored
    go0();
    chk("re_pc", pc0, 0);
    chk("re_acc", acc0, 0);
    chk("re_done", done0, 0);
    chk("re_rc", rc0, 0);
    tick();
    chk("re_mem_kept", acc0[7:0], 3);
    tick(2);
    start0 = 1;
    tick();
    start0 = 0;
    chk("sb_rc", rc0, 4);
    chk("sb_acc0", acc0[7:0], 1);
    chk("sb_pc0", pc0[3:0], 2);
    tick(10);
    chk("sb_done", done0, 1);
    chk("sb_rc14", rc0, 14);

    // wrap and modulo; last word written on the launch edge
    wr0(0, 0, 2, 250);
    wr0(0, 1, 3, 10);
    for (int a = 2; a < 15; a++) wr0(0, a, 1, 0);
    core0 = 0; addr0 = 15; data0 = {4'd3, 8'd1}; we0 = 1; start0 = 1;
    tick();
    we0 = 0; start0 = 0;
    chk("wl_err", err0, 0);
    tick(2);
    chk("wr_acc_e2", acc0[7:0], 4);
    tick(14);
    chk("wr_acc", acc0[7:0], 5);
    chk("wr_pc", pc0[3:0], 0);
    chk("wr_halted", halted0, 4'b1110);
    chk("wr_busy", busy0, 1);
    chk("wr_rc", rc0, 16);
    preset = 0;
    #1;
    chk("ab_busy", busy0, 0);
    chk("ab_acc", acc0, 0);
    chk("ab_pc", pc0, 0);
    chk("ab_rc", rc0, 0);
    preset = 1;
    tick();
    go0();
    tick();
    chk("ab_mem_lost", halted0, 4'hF);

    // single core: out-of-range core select
    core1 = 1; addr1 = 0; data1 = {4'd2, 8'd9}; we1 = 1;
    tick();
    we1 = 0;
    chk("n1_bad_core_err", err1, 1);
    core1 = 0; data1 = {4'd2, 8'd7}; we1 = 1;
    tick();
    we1 = 0;
    chk("n1_ok_err", err1, 0);
    start1 = 1;
    tick();
    start1 = 0;
    tick(2);
    chk("n1_acc", acc1, 7);
    chk("n1_pc", pc1, 1);
    chk("n1_halted", halted1, 1);
    chk("n1_done", done1, 1);

    // eight 16-bit cores
    wr2(7, 0, 2, 1);
    wr2(7, 1, 3, 16'hFFFF);
    wr2(2, 0, 2, 16'h1234);
    start2 = 1;
    tick();
    start2 = 0;
    tick();
    chk("n8_e1_acc7", acc2[127:112], 1);
    tick(2);
    chk("n8_acc7", acc2[127:112], 0);
    chk("n8_acc2", acc2[47:32], 16'h1234);
    chk("n8_pc7", pc2[31:28], 2);
    chk("n8_pc2", pc2[11:8], 1);
    chk("n8_halted", halted2, 8'hFF);
    chk("n8_done", done2, 1);
    chk("n8_rc", rc2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simplest_para_n.md
Name: simplest_para_n

Overview:
Parametrised successor of the fixed 4-core parallel accumulator machine. It has NUM_CORES independent single-cycle accumulator cores. Each core has a private program memory, loaded through one shared write port, and all cores launch together from a single start pulse. Per-core halt status, a common all_done flag and a shared run-cycle counter support multi-core benchmarks at the top level.

Parameters:
NUM_CORES, 4, number of cores (1..16)
ACC_W, 8, accumulator and immediate width
PROG_DEPTH, 16, instructions per core program memory (power of 2, >=2)
AW, $clog2(PROG_DEPTH), program address width (derived, not overridden)
CW, $clog2(NUM_CORES) min 1, core-select width (derived)

Ports:
clk  in  1  system clock, all state on rising edge
preset  in  1  asynchronous active-low reset
prog_we  in  1  program write strobe
prog_core  in  CW  target core for write
prog_addr  in  AW  target instruction address
prog_data  in  4+ACC_W  instruction: [ACC_W+3:ACC_W] opcode, [ACC_W-1:0] operand
prog_err  out  1  one-cycle pulse: write rejected
start  in  1  launch pulse
acc_out  out  NUM_CORES*ACC_W  packed accumulators, core k at [k*ACC_W +: ACC_W]
pc_out  out  NUM_CORES*AW  packed program counters
halted  out  NUM_CORES  per-core halted flag
busy  out  1  OR of cores in RUN
all_done  out  1  every core HALTED
run_cycles  out  16  cycles spent with busy=1 since last launch, saturating

Behaviour:
- Reset (preset=0, async): every core state=IDLE, acc=0, pc=0. Program memories cleared to 0 (= HALT). halted=0, all_done=0, busy=0, run_cycles=0, prog_err=0.
- Reset mid-run aborts immediately. Program contents are lost.
- Opcodes:
  0 HALT
  1 NOP
  2 LDI: acc=imm
  3 ADDI: acc=acc+imm
  4 SUBI: acc=acc-imm
  5 ANDI
  6 ORI
  7 XORI
  8 JMP: pc=imm[AW-1:0]
  9 JNZ: if acc!=0 pc=imm[AW-1:0] else pc+1
  10 JZ (converse of JNZ)
  11-15 behave as NOP.
- Arithmetic is modulo 2^ACC_W, with no carry or flags.
- Per-core FSM has three states: IDLE, RUN, HALTED.
  - IDLE/HALTED --start=1--> RUN at next edge, with acc=0, pc=0, halted=0, and run_cycles cleared to 0.
  - start while busy=1 is ignored, with no effect on any core.
- RUN: one instruction per cycle.
  - Instruction read is combinational from mem[core][pc]. acc/pc update on the edge.
  - A non-jump instruction sets pc=pc+1, wrapping PROG_DEPTH-1 -> 0.
  - HALT: at the edge the state goes to HALTED, halted=1, pc and acc hold.
- all_done = AND of halted.
  - It is registered and goes high the same edge the last core halts.
  - It stays high until the next start or reset.
- busy = any core in RUN.
  - run_cycles increments on each edge where busy=1 before the edge.
  - It saturates at 16'hFFFF.
- Program write:
  - Accepted on an edge with prog_we=1 and busy=0: mem[prog_core][prog_addr]=prog_data.
  - prog_we=1 while busy=1: write discarded, prog_err=1 for exactly one cycle.
  - prog_core>=NUM_CORES: discarded, prog_err=1.
- Simultaneous prog_we and start with busy=0: the write lands first. The launched cores see the new word from their first fetch.
- Outputs are registered state. acc_out/pc_out reflect the current registers.

Test Plan:
- Reset check: preset low at t=1, release at t=3 -> all acc_out=0, pc_out=0, halted=0, all_done=0. Any start with empty memories -> all cores halt after 1 RUN cycle, run_cycles=1.
- Straight-line program: load core0 {LDI 5, ADDI 3, HALT}, start -> core0 acc=8, pc=2, halted[0]=1 after 3 edges.
  - Other cores halt after 1 edge.
  - all_done rises on edge 3, run_cycles=3.
- Loop per core: core k runs {LDI k+3, SUBI 1, JNZ 1, HALT}. Cores halt at different times, ending with acc=0.
  - Core0 halts after 8 edges; core3 halts after 14 edges.
  - all_done rises on edge 14.
- Wrap and modulo (ACC_W=8):
  - {LDI 250, ADDI 10, NOP×13, ADDI 1} with no HALT and PROG_DEPTH=16 -> pc wraps 15->0. acc after the first pass is 5 (250+10 = 260 mod 256 = 4, then +1).
  - Reset terminates the run.
- Write protection: prog_we during RUN -> prog_err pulses 1 cycle and memory is unchanged. prog_core=NUM_CORES while idle -> prog_err=1.
- Start while busy is ignored: run_cycles is not cleared. Start after all_done relaunches with acc=0 and pc=0.
- Parameter sweep: NUM_CORES=1 and NUM_CORES=8, ACC_W=16 -> packed port slices are correct. Core 7 ADDI 16'hFFFF from 1 gives 0.
